// File: rtl/ball_tree_controller.sv
// rtl/ball_tree_controller.sv - ball-splitting level controller over a heap-indexed ball tree
module ball_tree_controller #(
    parameter int LEVELS = 3,
    parameter int CNT_W  = 8,
    localparam int N     = (1 << LEVELS) - 1
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             unitActive,
    input  logic [N-1:0]     colRope,
    input  logic [N-1:0]     colPlayer,
    output logic [N-1:0]     ballVisible,
    output logic [N-1:0]     ballSpawn,
    output logic [CNT_W-1:0] popCount,
    output logic             levelCleared,
    output logic             playerHit,
    output logic             col_rope_ball,
    output logic             col_player_ball
);

    localparam int FIRST_LEAF = (1 << (LEVELS - 1)) - 1;
    localparam int SUM_W      = ((CNT_W > 6) ? CNT_W : 6) + 1;
    localparam logic [N-1:0] ROOT = N'(1);

    typedef enum logic [2:0] {
        IDLE,
        DEPLOY,
        ACTIVE,
        HIT,
        CLEARED
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [N-1:0]     vis_next;
    logic [N-1:0]     spawn_next;
    logic [CNT_W-1:0] cnt_next;
    logic [N-1:0]     pops;
    logic [N-1:0]     children;
    logic             hit_any;
    logic [5:0]       pop_num;
    logic [SUM_W-1:0] pop_sum;

    assign col_rope_ball   = |(colRope & ballVisible);
    assign col_player_ball = |(colPlayer & ballVisible);

    // Pops only count on visible balls; each popped inner node spawns both children.
    always_comb begin
        pops     = colRope & ballVisible;
        hit_any  = |(colPlayer & ballVisible);
        children = '0;
        pop_num  = '0;
        for (int i = 0; i < FIRST_LEAF; i++) begin
            if (pops[i]) begin
                children[2*i+1] = 1'b1;
                children[2*i+2] = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            pop_num = pop_num + {5'b0, pops[i]};
        end
        pop_sum = SUM_W'(popCount) + SUM_W'(pop_num);
    end

    always_comb begin
        state_next = state;
        vis_next   = ballVisible;
        spawn_next = '0;
        cnt_next   = popCount;
        case (state)
            IDLE: begin
                vis_next = '0;
                if (unitActive) begin
                    state_next = DEPLOY;
                end
            end
            DEPLOY: begin
                state_next = ACTIVE;
                vis_next   = ROOT;
                spawn_next = ROOT;
                cnt_next   = '0;
            end
            ACTIVE: begin
                if (hit_any) begin
                    state_next = HIT;
                end else if (ballVisible == '0) begin
                    state_next = CLEARED;
                end else begin
                    vis_next   = (ballVisible & ~pops) | children;
                    spawn_next = children;
                    if (pop_sum > SUM_W'({CNT_W{1'b1}})) begin
                        cnt_next = '1;
                    end else begin
                        cnt_next = pop_sum[CNT_W-1:0];
                    end
                end
            end
            HIT, CLEARED: begin
                state_next = state;
            end
            default: begin
                state_next = IDLE;
                vis_next   = '0;
            end
        endcase
        // Dropping the level enable overrides everything else.
        if (!unitActive) begin
            state_next = IDLE;
            vis_next   = '0;
            spawn_next = '0;
            cnt_next   = popCount;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            ballVisible  <= '0;
            ballSpawn    <= '0;
            popCount     <= '0;
            levelCleared <= 1'b0;
            playerHit    <= 1'b0;
        end else begin
            ballVisible  <= vis_next;
            ballSpawn    <= spawn_next;
            popCount     <= cnt_next;
            levelCleared <= (state_next == CLEARED);
            playerHit    <= (state_next == HIT);
        end
    end

endmodule

// File: tb/tb_ball_tree_controller.sv
// tb/tb_ball_tree_controller.sv - directed scoreboard bench for ball_tree_controller
module tb_ball_tree_controller;

    logic       clk;
    logic       resetN;
    logic       unitActive;
    logic [6:0] colRope;
    logic [6:0] colPlayer;
    logic [6:0] ballVisible;
    logic [6:0] ballSpawn;
    logic [7:0] popCount;
    logic       levelCleared;
    logic       playerHit;
    logic       col_rope_ball;
    logic       col_player_ball;

    logic [6:0] s_vis;
    logic [6:0] s_spawn;
    logic [1:0] s_cnt;
    logic       s_clr;
    logic       s_hit;
    logic       s_crb;
    logic       s_cpb;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      tag;
        logic [6:0] vis;
        logic [6:0] spawn;
        logic [7:0] cnt;
        logic       clr;
        logic       hit;
    } exp_t;

    exp_t sb[$];

    ball_tree_controller #(.LEVELS(3), .CNT_W(8)) dut (
        .clk(clk), .resetN(resetN), .unitActive(unitActive),
        .colRope(colRope), .colPlayer(colPlayer),
        .ballVisible(ballVisible), .ballSpawn(ballSpawn), .popCount(popCount),
        .levelCleared(levelCleared), .playerHit(playerHit),
        .col_rope_ball(col_rope_ball), .col_player_ball(col_player_ball)
    );

    ball_tree_controller #(.LEVELS(3), .CNT_W(2)) dut_sat (
        .clk(clk), .resetN(resetN), .unitActive(unitActive),
        .colRope(colRope), .colPlayer(colPlayer),
        .ballVisible(s_vis), .ballSpawn(s_spawn), .popCount(s_cnt),
        .levelCleared(s_clr), .playerHit(s_hit),
        .col_rope_ball(s_crb), .col_player_ball(s_cpb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of stimulus, queue the expected registered result, then compare after the edge.
    task automatic step(input string tag, input logic ua, input logic [6:0] rope, input logic [6:0] ply,
                        input logic [6:0] vis, input logic [6:0] spawn, input logic [7:0] cnt,
                        input logic clr, input logic hit);
        exp_t e;
        unitActive = ua;
        colRope    = rope;
        colPlayer  = ply;
        sb.push_back('{tag, vis, spawn, cnt, clr, hit});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({e.tag, ".vis"}, 32'(ballVisible), 32'(e.vis));
        chk({e.tag, ".spawn"}, 32'(ballSpawn), 32'(e.spawn));
        chk({e.tag, ".cnt"}, 32'(popCount), 32'(e.cnt));
        chk({e.tag, ".clr"}, 32'(levelCleared), 32'(e.clr));
        chk({e.tag, ".hit"}, 32'(playerHit), 32'(e.hit));
    endtask

    initial begin
        resetN     = 1'b0;
        unitActive = 1'b0;
        colRope    = '0;
        colPlayer  = '0;
        #13;
        chk("rst.vis", 32'(ballVisible), 0);
        chk("rst.spawn", 32'(ballSpawn), 0);
        chk("rst.cnt", 32'(popCount), 0);
        chk("rst.flags", 32'({levelCleared, playerHit}), 0);
        @(posedge clk);
        #1;
        resetN = 1'b1;

        step("idle_hold", 1'b0, 7'h7f, 7'h00, 7'h00, 7'h00, 8'd0, 1'b0, 1'b0);
        step("t1_deploy", 1'b1, 7'h00, 7'h00, 7'h00, 7'h00, 8'd0, 1'b0, 1'b0);
        step("t2_active", 1'b1, 7'h00, 7'h00, 7'h01, 7'h01, 8'd0, 1'b0, 1'b0);
        step("t3_spawn0", 1'b1, 7'h00, 7'h00, 7'h01, 7'h00, 8'd0, 1'b0, 1'b0);

        colRope = 7'b0000001;
        #1;
        chk("comb.rope", 32'(col_rope_ball), 1);
        chk("comb.player", 32'(col_player_ball), 0);
        step("root_pop", 1'b1, 7'b0000001, 7'h00, 7'b0000110, 7'b0000110, 8'd1, 1'b0, 1'b0);
        step("root_pop_after", 1'b1, 7'h00, 7'h00, 7'b0000110, 7'h00, 8'd1, 1'b0, 1'b0);
        step("masked_pop", 1'b1, 7'b0100110, 7'h00, 7'b1111000, 7'b1111000, 8'd3, 1'b0, 1'b0);
        chk("sat.cnt3", 32'(s_cnt), 3);
        step("masked_after", 1'b1, 7'h00, 7'h00, 7'b1111000, 7'h00, 8'd3, 1'b0, 1'b0);
        step("leaf_pop", 1'b1, 7'b1111000, 7'h00, 7'h00, 7'h00, 8'd7, 1'b0, 1'b0);
        chk("sat.clamp", 32'(s_cnt), 3);
        step("cleared", 1'b1, 7'h00, 7'h00, 7'h00, 7'h00, 8'd7, 1'b1, 1'b0);
        step("cleared_frz", 1'b1, 7'h7f, 7'h7f, 7'h00, 7'h00, 8'd7, 1'b1, 1'b0);

        step("abort1", 1'b0, 7'h00, 7'h00, 7'h00, 7'h00, 8'd7, 1'b0, 1'b0);
        step("redeploy", 1'b1, 7'h00, 7'h00, 7'h00, 7'h00, 8'd7, 1'b0, 1'b0);
        step("reactive", 1'b1, 7'h00, 7'h00, 7'h01, 7'h01, 8'd0, 1'b0, 1'b0);
        step("pop2", 1'b1, 7'b0000001, 7'h00, 7'b0000110, 7'b0000110, 8'd1, 1'b0, 1'b0);

        colPlayer = 7'b0000010;
        colRope   = 7'b0000100;
        #1;
        chk("comb.player2", 32'(col_player_ball), 1);
        step("hit", 1'b1, 7'b0000100, 7'b0000010, 7'b0000110, 7'h00, 8'd1, 1'b0, 1'b1);
        step("hit_frz", 1'b1, 7'b0000110, 7'h00, 7'b0000110, 7'h00, 8'd1, 1'b0, 1'b1);
        step("abort2", 1'b0, 7'h00, 7'h00, 7'h00, 7'h00, 8'd1, 1'b0, 1'b0);

        step("deploy3", 1'b1, 7'h00, 7'h00, 7'h00, 7'h00, 8'd1, 1'b0, 1'b0);
        step("active3", 1'b1, 7'h00, 7'h00, 7'h01, 7'h01, 8'd0, 1'b0, 1'b0);
        step("pop3", 1'b1, 7'b0000001, 7'h00, 7'b0000110, 7'b0000110, 8'd1, 1'b0, 1'b0);
        step("abort_mid", 1'b0, 7'b0000010, 7'h00, 7'h00, 7'h00, 8'd1, 1'b0, 1'b0);

        #2;
        resetN = 1'b0;
        #1;
        chk("async_rst.cnt", 32'(popCount), 0);
        chk("async_rst.vis", 32'(ballVisible), 0);
        @(posedge clk);
        #1;
        resetN = 1'b1;
        step("post_rst_idle", 1'b0, 7'h00, 7'h00, 7'h00, 7'h00, 8'd0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
